// File: rtl/pq_arbiter.sv
// Round-robin scheduler that shares one max-at-head priority queue between
// NUM_REQ requesters, issuing one enqueue/dequeue/replace per 2+SETTLE_CYCLES cycles.
module pq_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int DATA_WIDTH    = 16,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                          i_CLK,
  input  logic                          i_RST,
  input  logic [NUM_REQ-1:0]            i_enq_req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_enq_data,
  input  logic [NUM_REQ-1:0]            i_deq_req,
  output logic [NUM_REQ-1:0]            o_enq_ack,
  output logic [NUM_REQ-1:0]            o_deq_ack,
  output logic                          o_rsp_valid,
  output logic [$clog2(NUM_REQ)-1:0]    o_rsp_id,
  output logic [DATA_WIDTH-1:0]         o_rsp_data,
  output logic                          o_zero_err,
  output logic                          o_pq_wrt,
  output logic                          o_pq_read,
  output logic [DATA_WIDTH-1:0]         o_pq_data,
  input  logic                          i_pq_full,
  input  logic                          i_pq_empty,
  input  logic [DATA_WIDTH-1:0]         i_pq_head
);
  localparam int ID_W        = $clog2(NUM_REQ);
  localparam int CNT_W       = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int SETTLE_LAST = (SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ISSUE = 2'd1, S_SETTLE = 2'd2} state_e;

  state_e                  state_q, state_d;
  logic [ID_W-1:0]         rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]         win_q, win_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [NUM_REQ-1:0]      enq_ack_q, enq_ack_d;
  logic [NUM_REQ-1:0]      deq_ack_q, deq_ack_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]         rsp_id_q, rsp_id_d;
  logic [DATA_WIDTH-1:0]   rsp_data_q, rsp_data_d;
  logic                    zero_err_q, zero_err_d;
  logic                    pq_wrt_q, pq_wrt_d;
  logic                    pq_read_q, pq_read_d;
  logic [DATA_WIDTH-1:0]   pq_data_q, pq_data_d;

  logic [NUM_REQ-1:0]      enq_elig_s, deq_elig_s, cand_s;
  logic                    found_s, hit_s;
  logic [ID_W-1:0]         win_s;
  int                      idx_s;
  logic [DATA_WIDTH-1:0]   win_data_s;
  logic                    enq_win_s, deq_win_s, zero_s;

  // A full queue still accepts an enqueue when it is paired with a dequeue (replace).
  assign deq_elig_s = i_deq_req & {NUM_REQ{~i_pq_empty}};
  assign enq_elig_s = i_enq_req & ~({NUM_REQ{i_pq_full}} & ~deq_elig_s);
  assign cand_s     = enq_elig_s | deq_elig_s;

  always_comb begin
    found_s = 1'b0;
    hit_s   = 1'b0;
    win_s   = '0;
    idx_s   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx_s   = (int'(rr_ptr_q) + k >= NUM_REQ) ? int'(rr_ptr_q) + k - NUM_REQ : int'(rr_ptr_q) + k;
      hit_s   = !found_s && cand_s[idx_s];
      win_s   = hit_s ? ID_W'(idx_s) : win_s;
      found_s = found_s | hit_s;
    end
  end

  assign win_data_s = i_enq_data[int'(win_s)*DATA_WIDTH +: DATA_WIDTH];
  assign enq_win_s  = enq_elig_s[win_s];
  assign deq_win_s  = deq_elig_s[win_s];
  assign zero_s     = (win_data_s == {DATA_WIDTH{1'b0}});

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    win_d       = win_q;
    cnt_d       = cnt_q;
    enq_ack_d   = '0;
    deq_ack_d   = '0;
    rsp_valid_d = 1'b0;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    zero_err_d  = zero_err_q;
    pq_wrt_d    = 1'b0;
    pq_read_d   = 1'b0;
    pq_data_d   = '0;
    case (state_q)
      S_IDLE: begin
        if (found_s) begin
          // Queue pins and acks are registered here so they are valid throughout ISSUE.
          win_d              = win_s;
          enq_ack_d[win_s]   = enq_win_s;
          deq_ack_d[win_s]   = deq_win_s;
          pq_wrt_d           = enq_win_s && !zero_s;
          pq_read_d          = deq_win_s;
          pq_data_d          = (enq_win_s && !zero_s) ? win_data_s : {DATA_WIDTH{1'b0}};
          zero_err_d         = zero_err_q | (enq_win_s && zero_s);
          state_d            = S_ISSUE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (pq_read_q) begin
          rsp_valid_d = 1'b1;
          rsp_id_d    = win_q;
          rsp_data_d  = i_pq_head;
        end else begin
          rsp_valid_d = 1'b0;
        end
        rr_ptr_d = (win_q == ID_W'(NUM_REQ - 1)) ? {ID_W{1'b0}} : win_q + ID_W'(1);
        cnt_d    = '0;
        state_d  = (SETTLE_CYCLES > 0) ? S_SETTLE : S_IDLE;
      end
      S_SETTLE: begin
        if (cnt_q == CNT_W'(SETTLE_LAST)) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      win_q       <= '0;
      cnt_q       <= '0;
      enq_ack_q   <= '0;
      deq_ack_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      zero_err_q  <= 1'b0;
      pq_wrt_q    <= 1'b0;
      pq_read_q   <= 1'b0;
      pq_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      win_q       <= win_d;
      cnt_q       <= cnt_d;
      enq_ack_q   <= enq_ack_d;
      deq_ack_q   <= deq_ack_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      zero_err_q  <= zero_err_d;
      pq_wrt_q    <= pq_wrt_d;
      pq_read_q   <= pq_read_d;
      pq_data_q   <= pq_data_d;
    end
  end

  assign o_enq_ack   = enq_ack_q;
  assign o_deq_ack   = deq_ack_q;
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_id    = rsp_id_q;
  assign o_rsp_data  = rsp_data_q;
  assign o_zero_err  = zero_err_q;
  assign o_pq_wrt    = pq_wrt_q;
  assign o_pq_read   = pq_read_q;
  assign o_pq_data   = pq_data_q;

endmodule

// File: tb/tb_pq_arbiter.sv
// Directed bench for pq_arbiter driving a small behavioural 4-entry max queue.
module tb_pq_arbiter;
  logic        i_CLK = 1'b0;
  logic        i_RST = 1'b1;
  logic [3:0]  i_enq_req = 4'h0;
  logic [63:0] i_enq_data = 64'h0;
  logic [3:0]  i_deq_req = 4'h0;
  logic [3:0]  o_enq_ack, o_deq_ack;
  logic        o_rsp_valid;
  logic [1:0]  o_rsp_id;
  logic [15:0] o_rsp_data;
  logic        o_zero_err, o_pq_wrt, o_pq_read;
  logic [15:0] o_pq_data;
  logic        i_pq_full, i_pq_empty;
  logic [15:0] i_pq_head;

  logic [63:0] m_q;
  int          m_cnt;
  int          errs   = 0;
  int          checks = 0;

  pq_arbiter #(.NUM_REQ(4), .DATA_WIDTH(16), .SETTLE_CYCLES(1)) dut (
    .i_CLK(i_CLK), .i_RST(i_RST),
    .i_enq_req(i_enq_req), .i_enq_data(i_enq_data), .i_deq_req(i_deq_req),
    .o_enq_ack(o_enq_ack), .o_deq_ack(o_deq_ack),
    .o_rsp_valid(o_rsp_valid), .o_rsp_id(o_rsp_id), .o_rsp_data(o_rsp_data),
    .o_zero_err(o_zero_err), .o_pq_wrt(o_pq_wrt), .o_pq_read(o_pq_read),
    .o_pq_data(o_pq_data), .i_pq_full(i_pq_full), .i_pq_empty(i_pq_empty),
    .i_pq_head(i_pq_head)
  );

  always #5 i_CLK = ~i_CLK;

  // Sorted insert into the descending model array (element 0 in the top bits).
  function automatic logic [63:0] q_ins(input logic [63:0] v, input int n, input logic [15:0] d);
    logic [15:0] a [0:4];
    int p;
    for (int i = 0; i < 4; i++) a[i] = v[63-16*i -: 16];
    a[4] = 16'h0;
    p = n;
    while (p > 0 && a[p-1] < d) begin
      a[p] = a[p-1];
      p--;
    end
    a[p] = d;
    for (int i = 0; i < 4; i++) q_ins[63-16*i -: 16] = a[i];
  endfunction

  assign i_pq_head  = m_q[63:48];
  assign i_pq_full  = (m_cnt == 4);
  assign i_pq_empty = (m_cnt == 0);

  always @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      m_q   <= 64'h0;
      m_cnt <= 0;
    end else if (o_pq_wrt && o_pq_read && m_cnt > 0) begin
      m_q <= q_ins(m_q << 16, m_cnt - 1, o_pq_data);
    end else if (o_pq_wrt && !o_pq_read && m_cnt < 4) begin
      m_q   <= q_ins(m_q, m_cnt, o_pq_data);
      m_cnt <= m_cnt + 1;
    end else if (o_pq_read && !o_pq_wrt && m_cnt > 0) begin
      m_q   <= m_q << 16;
      m_cnt <= m_cnt - 1;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Advance one cycle, then act as requesters that drop a request once acked.
  task automatic tick();
    @(posedge i_CLK);
    #1;
    i_enq_req = i_enq_req & ~o_enq_ack;
    i_deq_req = i_deq_req & ~o_deq_ack;
  endtask

  task automatic do_reset();
    i_RST = 1'b1;
    tick();
    tick();
    i_RST = 1'b0;
  endtask

  task automatic set_data(input int idx, input logic [15:0] val);
    i_enq_data[idx*16 +: 16] = val;
  endtask

  task automatic wait_ack(input string tag);
    int seen = 0;
    for (int n = 0; n < 20 && seen == 0; n++) begin
      tick();
      if ((o_enq_ack | o_deq_ack) != 4'h0) seen = 1;
    end
    check_val({tag, "_timeout"}, seen, 1);
  endtask

  initial begin
    int k;
    int last;
    int acks;

    // Reset state
    tick();
    tick();
    check_val("rst_outs", {o_enq_ack, o_deq_ack, o_rsp_valid, o_zero_err, o_pq_wrt, o_pq_read}, 32'h0);
    check_val("rst_data", {o_pq_data, o_rsp_data}, 32'h0);
    i_RST = 1'b0;

    // Single enqueue
    set_data(2, 16'h0050);
    i_enq_req = 4'b0100;
    tick();
    check_val("enq_ack", o_enq_ack, 32'h4);
    check_val("enq_wrt_rd", {o_pq_wrt, o_pq_read}, 32'h2);
    check_val("enq_data", o_pq_data, 32'h50);
    tick();
    check_val("enq_settle_wrt", o_pq_wrt, 32'h0);
    check_val("enq_head", i_pq_head, 32'h50);
    tick();

    // Round robin from reset
    do_reset();
    for (int i = 0; i < 4; i++) set_data(i, 16'((i + 1) * 16));
    i_enq_req = 4'hF;
    k = 0;
    last = 0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (o_enq_ack != 4'h0) begin
        check_val("rr_order", o_enq_ack, 32'(1 << k));
        if (k > 0) check_val("rr_spacing", c - last, 32'd3);
        last = c;
        k++;
      end
    end
    check_val("rr_count", k, 32'd4);
    check_val("rr_head", i_pq_head, 32'h40);

    // Dequeue response
    i_deq_req = 4'b0010;
    tick();
    check_val("deq_ack", {o_enq_ack, o_deq_ack}, 32'h02);
    check_val("deq_wrt_rd", {o_pq_wrt, o_pq_read}, 32'h1);
    tick();
    check_val("deq_rsp", {o_rsp_valid, o_rsp_id, o_rsp_data}, {13'h0, 1'b1, 2'd1, 16'h0040});
    check_val("deq_head", i_pq_head, 32'h30);
    tick();
    check_val("deq_rsp_pulse", o_rsp_valid, 32'h0);

    // Refill to full, then replace
    set_data(0, 16'h0040);
    i_enq_req = 4'b0001;
    wait_ack("refill");
    tick();
    tick();
    check_val("refill_full", i_pq_full, 32'h1);
    set_data(3, 16'h0025);
    i_enq_req = 4'b1000;
    i_deq_req = 4'b1000;
    wait_ack("repl");
    check_val("repl_ack", {o_enq_ack, o_deq_ack}, 32'h88);
    check_val("repl_wrt_rd", {o_pq_wrt, o_pq_read}, 32'h3);
    check_val("repl_data", o_pq_data, 32'h25);
    tick();
    check_val("repl_rsp", {o_rsp_valid, o_rsp_id, o_rsp_data}, {13'h0, 1'b1, 2'd3, 16'h0040});
    check_val("repl_full_head", {i_pq_full, i_pq_head}, {15'h0, 1'b1, 16'h0030});
    tick();

    // Blocking on full
    set_data(0, 16'h0050);
    i_enq_req = 4'b0001;
    acks = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if ((o_enq_ack | o_deq_ack) != 4'h0) acks++;
    end
    check_val("blk_no_grant", acks, 32'd0);
    i_deq_req = 4'b0100;
    wait_ack("blk_deq");
    check_val("blk_deq_ack", {o_enq_ack, o_deq_ack}, 32'h04);
    tick();
    check_val("blk_rsp", {o_rsp_valid, o_rsp_id, o_rsp_data}, {13'h0, 1'b1, 2'd2, 16'h0030});
    wait_ack("blk_enq");
    check_val("blk_enq_ack", {o_enq_ack, o_deq_ack}, 32'h10);
    check_val("blk_enq_data", {o_pq_wrt, o_pq_data}, {15'h0, 1'b1, 16'h0050});

    // Zero data and reset during ISSUE
    do_reset();
    set_data(1, 16'h0000);
    i_enq_req = 4'b0010;
    wait_ack("zero");
    check_val("zero_ack", o_enq_ack, 32'h2);
    check_val("zero_wrt", {o_pq_wrt, o_pq_read}, 32'h0);
    check_val("zero_err", o_zero_err, 32'h1);
    tick();
    tick();
    check_val("zero_sticky", o_zero_err, 32'h1);
    check_val("zero_empty", i_pq_empty, 32'h1);
    set_data(0, 16'h0033);
    i_enq_req = 4'b0001;
    wait_ack("pre_rst_enq");
    tick();
    tick();
    i_deq_req = 4'b0010;
    wait_ack("rst_deq");
    check_val("rst_deq_ack", {o_deq_ack, o_pq_read}, 32'h5);
    i_RST = 1'b1;
    tick();
    check_val("midrst_outs", {o_enq_ack, o_deq_ack, o_rsp_valid, o_zero_err, o_pq_wrt, o_pq_read}, 32'h0);
    check_val("midrst_data", {o_pq_data, o_rsp_data}, 32'h0);
    i_RST = 1'b0;
    acks = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (o_rsp_valid || (o_enq_ack | o_deq_ack) != 4'h0) acks++;
    end
    check_val("midrst_no_rsp", acks, 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
